// File: rtl/disp_arb_pkg.sv
// Shared constants, state type and priority helper for the display arbiter.
package disp_arb_pkg;

  localparam int unsigned NUM_SRC    = 3;
  localparam int unsigned SRC_ENTRY  = 0;
  localparam int unsigned SRC_RESULT = 1;
  localparam int unsigned SRC_ALERT  = 2;

  typedef enum logic [1:0] {IDLE, SHOW, LINGER} state_e;

  // Highest-priority requester as a one-hot vector: alert > result > entry.
  function automatic logic [NUM_SRC-1:0] pick_highest(input logic [NUM_SRC-1:0] req);
    pick_highest = '0;
    if (req[SRC_ALERT]) begin
      pick_highest[SRC_ALERT] = 1'b1;
    end else if (req[SRC_RESULT]) begin
      pick_highest[SRC_RESULT] = 1'b1;
    end else if (req[SRC_ENTRY]) begin
      pick_highest[SRC_ENTRY] = 1'b1;
    end
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks.
module tick_gen #(
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic Clk,
  input  logic Reset_n,
  output logic tick
);

  localparam int unsigned CntW = $clog2(TICK_DIV);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CntW'(TICK_DIV - 1));

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/display_arbiter.sv
// Shares the seven-segment display between entry, result and alert sources.
// Optional alert blinking is enabled by defining DISP_ALERT_BLINK_EN.
module display_arbiter
  import disp_arb_pkg::*;
#(
  parameter int unsigned WIDTH       = 13,
  parameter int unsigned TICK_DIV    = 100000,
  parameter int unsigned HOLD_TICKS  = 500,
  parameter int unsigned BLINK_TICKS = 250
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [NUM_SRC-1:0] Req_i,
  input  logic [WIDTH-1:0]   Entry_val,
  input  logic [WIDTH-1:0]   Result_val,
  input  logic [WIDTH-1:0]   Alert_code,
  output logic [WIDTH-1:0]   Number,
  output logic               Blank,
  output logic [NUM_SRC-1:0] Grant,
  output logic [NUM_SRC-1:0] Rel_o
);

  localparam int unsigned HoldW = $clog2(HOLD_TICKS + 1);

  logic tick;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .tick   (tick)
  );

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [NUM_SRC-1:0] rel_q, rel_d;
  logic [WIDTH-1:0]   number_q, number_d;
  logic               blank_q, blank_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic [WIDTH-1:0]   src_val [NUM_SRC];
  logic [WIDTH-1:0]   sel_val;
  logic [NUM_SRC-1:0] others;
  logic               expired, owner_req, alert_preempt;

  assign src_val[SRC_ENTRY]  = Entry_val;
  assign src_val[SRC_RESULT] = Result_val;
  assign src_val[SRC_ALERT]  = Alert_code;

  assign expired       = (hold_q == HoldW'(HOLD_TICKS));
  assign owner_req     = |(Req_i & grant_q);
  assign others        = Req_i & ~grant_q;
  assign alert_preempt = Req_i[SRC_ALERT] && !grant_q[SRC_ALERT];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    unique case (state_q)
      IDLE: begin
        if (|Req_i) begin
          state_d = SHOW;
          grant_d = pick_highest(Req_i);
        end
      end
      SHOW: begin
        // An alert owner keeps the display until it drops its own request.
        if (alert_preempt) begin
          grant_d = pick_highest(Req_i);
        end else if (expired && !grant_q[SRC_ALERT] && |others) begin
          grant_d = pick_highest(others);
        end else if (!owner_req) begin
          state_d = LINGER;
        end
      end
      LINGER: begin
        if (alert_preempt) begin
          state_d = SHOW;
          grant_d = pick_highest(Req_i);
        end else if (owner_req) begin
          state_d = SHOW;
        end else if (expired) begin
          state_d = (|Req_i) ? SHOW : IDLE;
          grant_d = pick_highest(Req_i);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    sel_val = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_d[i]) sel_val = sel_val | src_val[i];
    end
    number_d = (state_d == SHOW) ? sel_val : number_q;
    rel_d    = (grant_d != grant_q) ? grant_q : '0;
    if (grant_d != grant_q) begin
      hold_d = '0;
    end else if (tick && !expired) begin
      hold_d = hold_q + 1'b1;
    end else begin
      hold_d = hold_q;
    end
  end

`ifdef DISP_ALERT_BLINK_EN
  localparam int unsigned BlinkW = $clog2(2 * BLINK_TICKS);

  logic [BlinkW-1:0] blink_q, blink_d;

  // Phase counts ticks over one full visible+dark period; restarts on every alert grant.
  always_comb begin
    if (grant_d[SRC_ALERT] && !grant_q[SRC_ALERT]) begin
      blink_d = '0;
    end else if (grant_q[SRC_ALERT] && tick) begin
      blink_d = (blink_q == BlinkW'(2 * BLINK_TICKS - 1)) ? '0 : blink_q + 1'b1;
    end else begin
      blink_d = blink_q;
    end
    blank_d = (grant_d == '0) || (grant_d[SRC_ALERT] && (blink_d >= BlinkW'(BLINK_TICKS)));
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      blink_q <= '0;
    end else begin
      blink_q <= blink_d;
    end
  end
`else
  always_comb begin
    blank_d = (grant_d == '0);
  end
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rel_q    <= '0;
      number_q <= '0;
      blank_q  <= 1'b1;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rel_q    <= rel_d;
      number_q <= number_d;
      blank_q  <= blank_d;
      hold_q   <= hold_d;
    end
  end

  assign Number = number_q;
  assign Blank  = blank_q;
  assign Grant  = grant_q;
  assign Rel_o  = rel_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter: vector table, corner sequences, randomized model run.
module tb_display_arbiter;

  localparam int W  = 13;
  localparam int TD = 4;
  localparam int HT = 3;
  localparam int BT = 2;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic [2:0]    Req_i = '0;
  logic [W-1:0]  Entry_val = '0, Result_val = '0, Alert_code = '0;
  logic [W-1:0]  Number;
  logic          Blank;
  logic [2:0]    Grant, Rel_o;

  always #5 Clk = ~Clk;

  display_arbiter #(
    .WIDTH(W), .TICK_DIV(TD), .HOLD_TICKS(HT), .BLINK_TICKS(BT)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Req_i(Req_i), .Entry_val(Entry_val),
    .Result_val(Result_val), .Alert_code(Alert_code), .Number(Number),
    .Blank(Blank), .Grant(Grant), .Rel_o(Rel_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: owner index (-1 = nobody), whether the owner has let go,
  // ticks seen since the last owner change, and clock edges since reset.
  int           m_owner, m_rel, m_hold, m_blink, m_cyc;
  bit           m_linger;
  logic [W-1:0] m_num;
  logic         m_blank;

  function automatic int highest(input logic [2:0] m);
    for (int i = 2; i >= 0; i--) if (m[i]) return i;
    return -1;
  endfunction

  function automatic logic [2:0] onehot(input int idx);
    return (idx < 0) ? 3'b000 : (3'b001 << idx);
  endfunction

  task automatic model_reset();
    m_owner = -1; m_rel = -1; m_hold = 0; m_blink = 0; m_cyc = 0;
    m_linger = 0; m_num = '0; m_blank = 1'b1;
  endtask

  task automatic model_step(input logic [2:0] req, input logic [W-1:0] e, r, a);
    logic [W-1:0] vals [3];
    logic [2:0]   oth;
    int           nxt;
    bit           tick, expired;
    vals[0] = e; vals[1] = r; vals[2] = a;
    tick    = (m_cyc % TD) == TD - 1;
    expired = (m_hold == HT);
    nxt     = m_owner;
    if (m_owner < 0) begin
      if (req != 0) begin nxt = highest(req); m_linger = 0; end
    end else if (req[2] && m_owner != 2) begin
      nxt = 2; m_linger = 0;
    end else if (!m_linger) begin
      oth = req & ~onehot(m_owner);
      if (expired && m_owner != 2 && oth != 0) nxt = highest(oth);
      else if (!req[m_owner]) m_linger = 1;
    end else begin
      if (req[m_owner]) m_linger = 0;
      else if (expired) begin
        nxt = highest(req);
        m_linger = 0;
      end
    end
    if (nxt != m_owner) begin
      m_rel = m_owner; m_hold = 0;
      if (nxt == 2) m_blink = 0;
    end else begin
      m_rel = -1;
      if (tick && m_hold < HT) m_hold++;
      if (tick && m_owner == 2) m_blink++;
    end
    m_owner = nxt;
    m_cyc++;
    if (m_owner >= 0 && !m_linger) m_num = vals[m_owner];
    m_blank = (m_owner < 0);
`ifdef DISP_ALERT_BLINK_EN
    if (m_owner == 2 && ((m_blink / BT) % 2) == 1) m_blank = 1'b1;
`endif
  endtask

  task automatic step();
    @(posedge Clk);
    model_step(Req_i, Entry_val, Result_val, Alert_code);
    @(negedge Clk);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".grant"},  Grant,  onehot(m_owner));
    check({tag, ".number"}, Number, m_num);
    check({tag, ".blank"},  Blank,  m_blank);
    check({tag, ".rel"},    Rel_o,  onehot(m_rel));
  endtask

  // Asynchronous reset between edges; outputs must clear before any clock edge.
  task automatic async_reset(input string tag);
    @(negedge Clk);
    #1 Reset_n = 1'b0;
    #1;
    check({tag, ".rst_grant"},  Grant,  3'b000);
    check({tag, ".rst_number"}, Number, '0);
    check({tag, ".rst_blank"},  Blank,  1'b1);
    check({tag, ".rst_rel"},    Rel_o,  3'b000);
    Req_i = '0;
    @(negedge Clk);
    @(negedge Clk);
    model_reset();
    Reset_n = 1'b1;
  endtask

  typedef struct {
    logic [2:0]   req;
    logic [W-1:0] e, r, a;
    logic [2:0]   g;
    logic [W-1:0] n;
    logic         b;
    logic [2:0]   rel;
  } vec_t;

  vec_t tbl [18];

  initial begin
    // Row k is applied before the k-th clock edge after reset release.
    tbl[0]  = '{3'b000, 13'h0AA, 13'h000, 13'h000, 3'b000, 13'h000, 1'b1, 3'b000};
    tbl[1]  = '{3'b001, 13'h0AA, 13'h000, 13'h000, 3'b001, 13'h0AA, 1'b0, 3'b000};
    tbl[2]  = '{3'b001, 13'h0FF, 13'h000, 13'h000, 3'b001, 13'h0FF, 1'b0, 3'b000};
    tbl[3]  = '{3'b011, 13'h0FF, 13'h123, 13'h000, 3'b001, 13'h0FF, 1'b0, 3'b000};
    tbl[4]  = '{3'b011, 13'h0FF, 13'h123, 13'h000, 3'b001, 13'h0FF, 1'b0, 3'b000};
    tbl[5]  = '{3'b111, 13'h0FF, 13'h123, 13'h1EE, 3'b100, 13'h1EE, 1'b0, 3'b001};
    tbl[6]  = '{3'b011, 13'h0FF, 13'h123, 13'h1EE, 3'b100, 13'h1EE, 1'b0, 3'b000};
    tbl[7]  = '{3'b111, 13'h0FF, 13'h123, 13'h1EE, 3'b100, 13'h1EE, 1'b0, 3'b000};
    for (int k = 8; k < 16; k++)
      tbl[k] = '{3'b000, 13'h0FF, 13'h123, 13'h0BB, 3'b100, 13'h1EE, 1'b0, 3'b000};
    tbl[16] = '{3'b000, 13'h0FF, 13'h123, 13'h0BB, 3'b000, 13'h1EE, 1'b1, 3'b100};
    tbl[17] = '{3'b000, 13'h0FF, 13'h123, 13'h0BB, 3'b000, 13'h1EE, 1'b1, 3'b000};

    model_reset();
    Req_i = 3'b000;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;

    // Vector table, starting from reset.
    for (int k = 0; k < 18; k++) begin
      Req_i = tbl[k].req; Entry_val = tbl[k].e; Result_val = tbl[k].r; Alert_code = tbl[k].a;
      step();
      check($sformatf("tbl%0d.grant", k),  Grant,  tbl[k].g);
      check($sformatf("tbl%0d.number", k), Number, tbl[k].n);
`ifdef DISP_ALERT_BLINK_EN
      if (tbl[k].g != 3'b100) check($sformatf("tbl%0d.blank", k), Blank, tbl[k].b);
`else
      check($sformatf("tbl%0d.blank", k), Blank, tbl[k].b);
`endif
      check($sformatf("tbl%0d.rel", k), Rel_o, tbl[k].rel);
    end

    // Reset mid-SHOW, then stay idle with no requests.
    Req_i = 3'b001;
    step();
    async_reset("rst_show");
    repeat (3) begin
      step();
      check("rst_idle.grant", Grant, 3'b000);
      check("rst_idle.blank", Blank, 1'b1);
    end

    // Rotation after hold expiry: entry granted at edge 0, result waits for 3 ticks.
    async_reset("rot");
    Req_i = 3'b001; Entry_val = 13'h0AA; Result_val = 13'h123; Alert_code = 13'h1EE;
    step();
    Req_i = 3'b011;
    for (int k = 1; k < 12; k++) begin
      step();
      check("rot.wait_grant", Grant, 3'b001);
      check("rot.wait_rel", Rel_o, 3'b000);
    end
    step();
    check("rot.grant", Grant, 3'b010);
    check("rot.number", Number, 13'h123);
    check("rot.rel", Rel_o, 3'b001);
    step();
    check("rot.rel_once", Rel_o, 3'b000);
    // Alert preempts an unexpired result owner, then is not displaced by 011.
    Req_i = 3'b111;
    step();
    check("pre.grant", Grant, 3'b100);
    check("pre.number", Number, 13'h1EE);
    check("pre.rel", Rel_o, 3'b010);
    Req_i = 3'b011;
    repeat (2) begin
      step();
      check("pre.keep_alert", Grant, 3'b100);
    end

    // Linger: re-request before expiry keeps the grant and does not reset hold.
    async_reset("lin");
    Req_i = 3'b001; Entry_val = 13'h055;
    step();
    Req_i = 3'b000; Entry_val = 13'h077;
    repeat (2) begin
      step();
      check("lin.frozen", Number, 13'h055);
      check("lin.blank", Blank, 1'b0);
      check("lin.grant", Grant, 3'b001);
    end
    Req_i = 3'b001;
    step();
    check("lin.regrant", Grant, 3'b001);
    check("lin.regrant_rel", Rel_o, 3'b000);
    check("lin.regrant_num", Number, 13'h077);
    Req_i = 3'b000; Entry_val = 13'h011;
    for (int k = 4; k < 12; k++) begin
      step();
      check("lin.hold_grant", Grant, 3'b001);
      check("lin.hold_num", Number, 13'h077);
    end
    step();
    check("lin.idle_grant", Grant, 3'b000);
    check("lin.idle_blank", Blank, 1'b1);
    check("lin.idle_rel", Rel_o, 3'b001);

    // Alert held for a while: blank follows the blink phase when enabled.
    async_reset("blink");
    Req_i = 3'b100; Alert_code = 13'h1AB;
    for (int k = 0; k < 40; k++) begin
      step();
      check_model("blink");
`ifndef DISP_ALERT_BLINK_EN
      check("blink.steady", Blank, 1'b0);
`endif
    end

    // Randomized run against the model, with one asynchronous reset midway.
    async_reset("rnd");
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) async_reset("rnd_mid");
      if ($urandom_range(3) == 0) Req_i = 3'($urandom_range(7));
      if ($urandom_range(7) == 0) Req_i[2] = 1'b0;
      if ($urandom_range(1) == 0) Entry_val = W'($urandom);
      if ($urandom_range(3) == 0) Result_val = W'($urandom);
      if ($urandom_range(3) == 0) Alert_code = W'($urandom);
      step();
      check_model("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
